// File: rtl/npu_feed_skew.sv
// Buffers an N x N operand matrix from a row-per-beat valid/ready stream, then
// clears the NPU and feeds it the matrix with diagonal (systolic) skew.
module npu_feed_skew #(
  parameter int N         = 4,
  parameter int W         = 16,
  parameter int DRAIN_MAX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_row [N],
  output logic         npu_rst,
  output logic         npu_enable,
  output logic [W-1:0] npu_in [N],
  input  logic         npu_done,
  output logic         busy,
  output logic         frame_done,
  output logic         err
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(N + 1);
  localparam int FW = $clog2(2 * N);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_FEED,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [FW-1:0] feed_cnt_q, feed_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          err_q, err_d;
  logic          frame_done_q, frame_done_d;
  logic [W-1:0]  mat_q [N][N];
  logic [W-1:0]  mat_d [N][N];

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    feed_cnt_d   = feed_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    mat_d        = mat_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mat_d[0]  = in_row;
          row_cnt_d = RW'(1);
          err_d     = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          mat_d[AW'(row_cnt_q)] = in_row;
          row_cnt_d             = row_cnt_q + RW'(1);
          if (row_cnt_q == RW'(N - 1)) state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (npu_done) err_d = 1'b1;
        feed_cnt_d = '0;
        state_d    = S_FEED;
      end
      S_FEED: begin
        if (npu_done) err_d = 1'b1;
        if (feed_cnt_q == FW'(2 * N - 2)) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else begin
          feed_cnt_d = feed_cnt_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (npu_done) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else if (drain_cnt_q == DW'(DRAIN_MAX - 1)) begin
          err_d        = 1'b1;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      row_cnt_q    <= '0;
      feed_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      feed_cnt_q   <= feed_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Matrix storage needs no reset; it is fully rewritten before every feed.
  always_ff @(posedge clk) begin
    mat_q <= mat_d;
  end

  // The reset input gates the handshake and NPU clear so both hold their
  // reset values while rst is low, not only after the next edge.
  assign in_ready   = rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign npu_rst    = rst && (state_q != S_CLEAR);
  assign npu_enable = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign err        = err_q;

  // Lane i sees row (feed_cnt - i), column i: one anti-diagonal per cycle.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [FW-1:0] diag;
    assign diag      = feed_cnt_q - FW'(i);
    assign npu_in[i] = ((state_q == S_FEED) && (feed_cnt_q >= FW'(i)) && (diag < FW'(N)))
                       ? mat_q[AW'(diag)][i] : '0;
  end

endmodule

// File: tb/tb_npu_feed_skew.sv
// Directed self-checking bench for npu_feed_skew: load, skewed feed, drain,
// timeout, early done, mid-frame reset and back-to-back frames.
module tb_npu_feed_skew;
  localparam int N         = 4;
  localparam int W         = 16;
  localparam int DRAIN_MAX = 16;

  typedef logic [W-1:0] mat_t [N][N];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_row [N];
  logic         npu_rst;
  logic         npu_enable;
  logic [W-1:0] npu_in [N];
  logic         npu_done;
  logic         busy;
  logic         frame_done;
  logic         err;

  int tests = 0;
  int fails = 0;

  npu_feed_skew #(.N(N), .W(W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .npu_rst(npu_rst), .npu_enable(npu_enable), .npu_in(npu_in), .npu_done(npu_done),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input mat_t rows, input int gaps [N]);
    for (int r = 0; r < N; r++) begin
      in_valid = 1'b0;
      for (int c = 0; c < N; c++) in_row[c] = 16'hDEAD;
      for (int g = 0; g < gaps[r]; g++) tick();
      in_valid = 1'b1;
      in_row   = rows[r];
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL load_ready row %0d: got %b want 1", r, in_ready);
      end
      tick();
      tests++;
      if (busy !== 1'b1 || err !== 1'b0) begin
        fails++;
        $display("FAIL load_state row %0d: busy=%b err=%b want busy=1 err=0", r, busy, err);
      end
    end
    in_valid = 1'b0;
  endtask

  // Called in the CLEAR cycle; returns at the frame_done cycle (or one later when !b2b).
  task automatic feed(input mat_t rows, input int early_at, input int done_at,
                      input logic exp_err, input bit b2b);
    logic [W-1:0] exp_v;
    int d;
    bit left;
    tests++;
    if (npu_rst !== 1'b0 || npu_enable !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL clear: npu_rst=%b en=%b rdy=%b busy=%b want 0 0 0 1",
               npu_rst, npu_enable, in_ready, busy);
    end
    tick();
    for (int k = 0; k < 2 * N - 1; k++) begin
      npu_done = (k == early_at);
      tests++;
      if (npu_enable !== 1'b1 || npu_rst !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL feed_ctrl k=%0d: en=%b npu_rst=%b rdy=%b want 1 1 0",
                 k, npu_enable, npu_rst, in_ready);
      end
      for (int i = 0; i < N; i++) begin
        exp_v = (k - i >= 0 && k - i < N) ? rows[k - i][i] : '0;
        tests++;
        if (npu_in[i] !== exp_v) begin
          fails++;
          $display("FAIL feed_data k=%0d lane %0d: got %h want %h", k, i, npu_in[i], exp_v);
        end
      end
      tick();
    end
    npu_done = 1'b0;
    d = 0;
    left = 0;
    while (!left && d < DRAIN_MAX + 2) begin
      if (busy !== 1'b1) begin
        left = 1;
      end else begin
        tests++;
        if (npu_enable !== 1'b1 || npu_in[0] !== '0 || npu_in[N-1] !== '0) begin
          fails++;
          $display("FAIL drain d=%0d: en=%b lane0=%h lane3=%h want 1 0 0",
                   d, npu_enable, npu_in[0], npu_in[N-1]);
        end
        npu_done = (d == done_at);
        tick();
        d++;
      end
    end
    npu_done = 1'b0;
    tests++;
    if (!left || d !== ((done_at >= 0) ? done_at + 1 : DRAIN_MAX)) begin
      fails++;
      $display("FAIL drain_len: got %0d cycles (left=%0d) want %0d",
               d, left, (done_at >= 0) ? done_at + 1 : DRAIN_MAX);
    end
    tests++;
    if (frame_done !== 1'b1 || npu_enable !== 1'b0 || err !== exp_err || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL frame_end: fd=%b en=%b err=%b rdy=%b want 1 0 %b 1",
               frame_done, npu_enable, err, in_ready, exp_err);
    end
    if (!b2b) begin
      tick();
      tests++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL frame_after: fd=%b busy=%b rdy=%b want 0 0 1", frame_done, busy, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    npu_done = 1'b0;
    for (int c = 0; c < N; c++) in_row[c] = '0;
    tick();
    tick();
    tests++;
    if (in_ready !== 1'b0 || npu_rst !== 1'b0 || npu_enable !== 1'b0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: rdy=%b npu_rst=%b en=%b busy=%b fd=%b err=%b want all 0",
               in_ready, npu_rst, npu_enable, busy, frame_done, err);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (npu_in[i] !== '0) begin
        fails++;
        $display("FAIL reset_data lane %0d: got %h want 0", i, npu_in[i]);
      end
    end
    rst = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || npu_rst !== 1'b1) begin
      fails++;
      $display("FAIL idle_after_reset: rdy=%b npu_rst=%b want 1 1", in_ready, npu_rst);
    end
  endtask

  task automatic test_basic();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = W'(r * N + c + 1);
    load(m, '{0, 0, 0, 0});
    feed(m, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = W'(16'h0100 * (r + 1) + c);
    load(m, '{0, 0, 0, 0});
    feed(m, -1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_gaps();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = W'(10 * (c + 1));
    load(m, '{0, 2, 0, 4});
    feed(m, -1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_early_done();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = W'(16'hF000 + r * 16 + c);
    load(m, '{0, 1, 0, 0});
    feed(m, 2, 0, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    mat_t m;
    mat_t z;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m[r][c] = W'(16'h1234 + r + c);
        z[r][c] = '0;
      end
    load(m, '{0, 0, 0, 0});
    tick();
    for (int k = 0; k < 3; k++) tick();
    tests++;
    if (npu_enable !== 1'b1 || npu_in[3] !== m[0][3]) begin
      fails++;
      $display("FAIL pre_reset_feed3: en=%b lane3=%h want 1 %h", npu_enable, npu_in[3], m[0][3]);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (npu_enable !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || npu_rst !== 1'b0 ||
        frame_done !== 1'b0 || npu_in[0] !== '0 || npu_in[3] !== '0) begin
      fails++;
      $display("FAIL mid_reset: en=%b busy=%b rdy=%b npu_rst=%b fd=%b l0=%h l3=%h want all 0",
               npu_enable, busy, in_ready, npu_rst, frame_done, npu_in[0], npu_in[3]);
    end
    tick();
    tests++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_hold: fd=%b busy=%b want 0 0", frame_done, busy);
    end
    rst = 1'b1;
    tick();
    load(z, '{0, 0, 0, 0});
    feed(z, -1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    mat_t a;
    mat_t b;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a[r][c] = ((r + c) % 2 == 0) ? 16'hAAAA : 16'h5555;
        b[r][c] = ((r + c) % 2 == 0) ? 16'h5555 : 16'hAAAA;
      end
    load(a, '{0, 0, 0, 0});
    feed(a, -1, 1, 1'b0, 1'b1);
    load(b, '{0, 0, 0, 0});
    feed(b, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_gaps();
    test_early_done();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
